// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch FSM feeding decode through a 2-entry FIFO; define IFU_BYPASS_EN for same-cycle rvalid-to-decode bypass
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [7:0]  dec_opcode,
  output logic [31:0] dec_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, STALL} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_apc;
  logic        r_kill, r_rd, r_wr;
  logic [1:0]  r_cnt;
  logic [31:0] r_fi [2];
  logic [31:0] r_fp [2];
  logic [31:0] w_rpc;
  logic        w_take, w_byp, w_valid, w_pop, w_push;
  logic [1:0]  w_cnt_n;
  always_comb begin
    w_rpc = redirect_pc & ~32'h3;
    w_take = r_state == WAIT && imem_rvalid && !r_kill && !redirect;
`ifdef IFU_BYPASS_EN
    w_byp = w_take && r_cnt == 2'd0;
`else
    w_byp = 1'b0;
`endif
    w_valid = !reset && (r_cnt != 2'd0 || w_byp);
    w_pop = w_valid && dec_ready && !redirect && r_cnt != 2'd0;
    w_push = w_take && !(w_byp && dec_ready);
    w_cnt_n = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    imem_req = !reset && r_state == REQ;
    imem_addr = imem_req ? r_pc : 32'h0;
    dec_valid = w_valid;
    dec_instr = !w_valid ? 32'h0 : w_byp ? imem_rdata : r_fi[r_rd];
    dec_pc = !w_valid ? 32'h0 : w_byp ? r_apc : r_fp[r_rd];
    dec_opcode = dec_instr[31:24];
  end
  always_ff @(posedge clk)
    if (w_push) begin
      r_fi[r_wr] <= imem_rdata;
      r_fp[r_wr] <= r_apc;
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_apc <= 32'h0;
      r_kill <= 1'b0;
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= redirect ? 2'd0 : w_cnt_n;
      r_rd <= redirect ? 1'b0 : r_rd ^ w_pop;
      r_wr <= redirect ? 1'b0 : r_wr ^ w_push;
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          if (redirect) r_pc <= w_rpc;
        end
        REQ:
          if (redirect) begin
            r_pc <= w_rpc;
            r_kill <= imem_gnt;
            r_state <= imem_gnt ? WAIT : REQ;
          end else if (imem_gnt) begin
            r_apc <= r_pc;
            r_pc <= r_pc + 32'd4;
            r_state <= WAIT;
          end
        WAIT:
          if (imem_rvalid) begin
            r_kill <= 1'b0;
            r_state <= (r_kill || redirect || w_cnt_n != 2'd2) ? REQ : STALL;
            if (redirect) r_pc <= w_rpc;
          end else if (redirect) begin
            r_kill <= 1'b1;
            r_pc <= w_rpc;
          end
        STALL:
          if (redirect) begin
            r_pc <= w_rpc;
            r_state <= REQ;
          end else if (w_pop) r_state <= REQ;
      endcase
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a latency-programmable memory model
module tb_ifu_fetch;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;
`ifdef IFU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic imem_req, imem_gnt = 0, imem_rvalid = 0, dec_valid, dec_ready = 1, redirect = 0;
  logic [31:0] imem_addr, imem_rdata = 0, dec_instr, dec_pc, redirect_pc = 0;
  logic [7:0] dec_opcode;
  logic req1, valid1, rvalid1 = 0;
  logic [31:0] addr1, instr1, pc1;
  logic [7:0] op1;
  int n_cmp = 0, n_bad = 0;
  logic gnt_en = 1;
  logic [31:0] stop_addr = 32'hC, paddr = 0;
  int mem_lat = 1, pend = 0;
  logic p1 = 0;
  logic [63:0] q[$];
  logic [63:0] e;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_opcode(dec_opcode), .dec_pc(dec_pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );
  ifu_fetch #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1), .imem_gnt(1'b1),
    .imem_rvalid(rvalid1), .imem_rdata(32'h5A00_0001), .dec_valid(valid1), .dec_ready(1'b1),
    .dec_instr(instr1), .dec_opcode(op1), .dec_pc(pc1), .redirect(1'b0), .redirect_pc(32'h0)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[9:2] ^ 8'h3C, 8'hA5, a[15:0]};
  endfunction
  task automatic expect_word(input logic [31:0] a);
    q.push_back({a, mem(a)});
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_req"}, 32'(imem_req), 32'h0);
    chk({n, "_addr"}, imem_addr, 32'h0);
    chk({n, "_valid"}, 32'(dec_valid), 32'h0);
    chk({n, "_instr"}, dec_instr, 32'h0);
    chk({n, "_opcode"}, 32'(dec_opcode), 32'h0);
    chk({n, "_pc"}, dec_pc, 32'h0);
  endtask
  task automatic wait_req(input logic [31:0] a, input string n);
    int k = 0;
    while (!(imem_req && imem_gnt && imem_addr == a) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(n, 32'(imem_req && imem_gnt && imem_addr == a), 32'h1);
  endtask
  task automatic drain(input string n);
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(n, q.size(), 32'h0);
  endtask
  initial forever begin
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      pend = mem_lat;
      paddr = imem_addr;
    end
    p1 = req1;
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rvalid = 1;
        imem_rdata = mem(paddr);
      end
    end
    imem_gnt = gnt_en && imem_addr != stop_addr;
    rvalid1 = p1;
  end
  initial forever begin
    @(negedge clk);
    if (!reset && dec_valid && dec_ready && !redirect) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got pc %h instr %h, want none", dec_pc, dec_instr);
      end else begin
        e = q.pop_front();
        chk("dec_pc", dec_pc, e[63:32]);
        chk("dec_instr", dec_instr, e[31:0]);
        chk("dec_opcode", 32'(dec_opcode), 32'(e[31:24]));
      end
    end
  end
  initial begin
    logic [31:0] a[2];
    logic [31:0] pcv;
    int n = 0;
    logic got = 0;
    do @(negedge clk); while (reset);
    for (int k = 0; k < 30 && (n < 2 || !got); k++) begin
      if (req1 && n < 2) begin
        a[n] = addr1;
        n++;
      end
      if (valid1 && !got) begin
        pcv = pc1;
        got = 1;
      end
      @(negedge clk);
    end
    chk("rstpc_fetches", n, 32'd2);
    chk("rstpc_first", a[0], 32'hFFFF_FFFC);
    chk("rstpc_wrap", a[1], 32'h0);
    chk("rstpc_dec_pc", pcv, 32'hFFFF_FFFC);
  end
  initial begin
    int k;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    @(negedge clk);
    chk_idle("in_rst");
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_idle("post_rst");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!imem_rvalid && k < 20);
    chk("lat_seen", 32'(imem_rvalid), 32'h1);
    chk("lat_n", 32'(dec_valid), 32'(BYP));
    @(negedge clk);
    chk("lat_n1", 32'(dec_valid), 32'(!BYP));
    drain("p1_drain");
    repeat (3) @(negedge clk);
    chk("p1_hold_req", 32'(imem_req), 32'h1);
    chk("p1_hold_addr", imem_addr, 32'hC);
    @(posedge clk);
    #1 dec_ready = 0;
    @(negedge clk);
    stop_addr = NONE;
    expect_word(32'hC);
    expect_word(32'h10);
    repeat (10) @(negedge clk);
    chk("stall_req", 32'(imem_req), 32'h0);
    chk("stall_valid", 32'(dec_valid), 32'h1);
    chk("stall_head", dec_pc, 32'hC);
    expect_word(32'h14);
    expect_word(32'h18);
    stop_addr = 32'h1C;
    @(posedge clk);
    #1 dec_ready = 1;
    drain("p2_drain");
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    mem_lat = 3;
    stop_addr = 32'h108;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h100);
    expect_word(32'h104);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    wait_req(32'h8, "p3_req8");
    @(posedge clk);
    #1 redirect = 1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("p3_wait_noreq", 32'(imem_req), 32'h0);
    @(posedge clk);
    #1 redirect = 0;
    @(negedge clk);
    chk("p3_flush", 32'(dec_valid), 32'h0);
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("p3_redir_addr", imem_addr, 32'h100);
    drain("p3_drain");
    @(negedge clk);
    gnt_en = 0;
    @(posedge clk);
    #1 redirect = 1;
    redirect_pc = 32'h3F0;
    @(posedge clk);
    #1 redirect = 0;
    @(negedge clk);
    chk("req_redir_req", 32'(imem_req), 32'h1);
    chk("req_redir_addr", imem_addr, 32'h3F0);
    @(negedge clk);
    chk("req_redir_hold", imem_addr, 32'h3F0);
    gnt_en = 1;
    mem_lat = 2;
    stop_addr = NONE;
    @(negedge clk);
    gnt_en = 0;
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk_idle("rst_wait");
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk_idle("rst_rvalid");
    @(negedge clk);
    chk("rst_drop", 32'(dec_valid), 32'h0);
    chk("rst_refetch_req", 32'(imem_req), 32'h1);
    chk("rst_refetch_addr", imem_addr, 32'h0);
    gnt_en = 1;
    mem_lat = 1;
    stop_addr = 32'h208;
    wait_req(32'h0, "p4_req0");
    @(posedge clk);
    #1 redirect = 1;
    redirect_pc = 32'h203;
    expect_word(32'h200);
    expect_word(32'h204);
    @(negedge clk);
    chk("p4_stale", 32'(dec_valid), 32'h0);
    @(posedge clk);
    #1 redirect = 0;
    @(negedge clk);
    chk("p4_req", 32'(imem_req), 32'h1);
    chk("p4_addr", imem_addr, 32'h200);
    chk("p4_novalid", 32'(dec_valid), 32'h0);
    drain("p4_drain");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the byte address of the first fetch after reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch byte address, word-aligned.
REQ-006 imem_gnt  input  1  memory accepted request this cycle.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 dec_valid  output  1  instruction available to decode.
REQ-010 dec_ready  input  1  decode accepts instruction.
REQ-011 dec_instr  output  32  instruction word to decode.
REQ-012 dec_opcode  output  8  dec_instr[31:24], the 8-bit opcode consumed by the control decoder.
REQ-013 dec_pc  output  32  byte address of dec_instr.
REQ-014 redirect  input  1  branch/JAL taken, flush and refetch.
REQ-015 redirect_pc  input  32  new fetch address, valid when redirect=1.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, STALL; at most one memory request outstanding.
REQ-017 IDLE -> REQ unconditionally one cycle after reset deasserts.
REQ-018 REQ: imem_req=1, imem_addr=fetch PC; on imem_gnt -> WAIT, fetch PC += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0).
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0, except on redirect.
REQ-020 WAIT: on imem_rvalid, push {pc, rdata} into a 2-entry FIFO; -> REQ if FIFO will have a free entry, else -> STALL.
REQ-021 STALL: -> REQ in the cycle after a FIFO pop; imem_req=0 in STALL.
REQ-022 dec_valid = FIFO not empty; dec_instr/dec_opcode/dec_pc SHALL show FIFO head; pop on dec_valid && dec_ready.
REQ-023 Push and pop in same cycle with FIFO full SHALL be legal; occupancy unchanged, order preserved.
REQ-024 Base latency: imem_rvalid at cycle N -> dec_valid at N+1 when FIFO empty.
REQ-025 redirect SHALL flush FIFO and suppress any pop that cycle; dec_valid=0 next cycle.
REQ-026 redirect in REQ without gnt: next cycle imem_addr=redirect_pc, imem_req stays 1.
REQ-027 redirect in REQ coinciding with gnt, or in WAIT: set kill flag; the matching response SHALL be discarded, then REQ at redirect_pc.
REQ-028 redirect in the same cycle as imem_rvalid: that data SHALL be discarded; next state REQ at redirect_pc.
REQ-029 redirect in IDLE or STALL: next state REQ at redirect_pc.
REQ-030 redirect_pc[1:0] SHALL be forced to 2'b00.

Reset
REQ-031 reset SHALL set state=IDLE, fetch PC=RESET_PC, FIFO empty, kill=0.
REQ-032 During and one cycle after reset: imem_req=0, imem_addr=0, dec_valid=0, dec_instr=0, dec_opcode=0, dec_pc=0.
REQ-033 reset mid-WAIT SHALL drop the outstanding response; an imem_rvalid in the first cycle after reset SHALL be ignored.

Configuration
REQ-034 Macro IFU_BYPASS_EN: when defined, with FIFO empty and imem_rvalid=1 (not killed), imem_rdata SHALL drive dec_* combinationally with dec_valid=1 in cycle N; if dec_ready=1 the word is not pushed.
REQ-035 Without IFU_BYPASS_EN, dec_* SHALL be driven from FIFO registers only (latency per REQ-024).

Verification
REQ-036 Reset, memory gnt=1 always, rvalid 1 cycle after gnt, dec_ready=1 -> addrs 0x0,0x4,0x8 in order; dec_opcode = rdata[31:24].
REQ-037 dec_ready=0 for 10 cycles -> FIFO fills with 2 words, state STALL, imem_req=0; dec_ready=1 -> words emitted in order, fetch resumes.
REQ-038 redirect to 0x100 while WAIT for 0x8 -> 0x8 data discarded, next imem_addr=0x100, next dec_pc=0x100.
REQ-039 redirect_pc=0x203 with rvalid same cycle -> next imem_addr=0x200, no stale dec_valid.
REQ-040 RESET_PC=0xFFFF_FFFC -> second fetch address 0x0000_0000.
REQ-041 IFU_BYPASS_EN defined, FIFO empty, rvalid at N -> dec_valid at N; undefined -> dec_valid at N+1.
